// File: rtl/imem_arbiter.sv
// Single-port instruction SRAM arbiter: the loader writes, fetch reads, and a
// starvation counter guarantees fetch eventually wins against a busy loader.
module imem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              f_req_i,
  input  logic [31:0]       f_addr_i,
  input  logic              f_flush_i,
  output logic              f_gnt_o,
  output logic              f_rvalid_o,
  output logic [31:0]       f_rdata_o,
  input  logic              l_req_i,
  input  logic [31:0]       l_addr_i,
  input  logic [31:0]       l_wdata_i,
  output logic              l_gnt_o,
  output logic              l_done_o,
  output logic              mem_csb_o,
  output logic              mem_web_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_din_o,
  input  logic [31:0]       mem_dout_i
);

  // state | meaning
  // IDLE  | no grant last cycle
  // RD    | fetch granted last cycle, read data on mem_dout_i now
  // WR    | loader granted last cycle, write has completed
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_next;
  logic             f_gnt;
  logic             l_gnt;

  // Byte-offset and upper address bits never reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr_i[31:ADDR_W+2], f_addr_i[1:0],
                              l_addr_i[31:ADDR_W+2], l_addr_i[1:0]};

  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset_i) begin
      if (f_req_i && l_req_i) begin
        if (starve_cnt == LIMIT) f_gnt = 1'b1;
        else                     l_gnt = 1'b1;
      end else if (l_req_i) begin
        l_gnt = 1'b1;
      end else if (f_req_i) begin
        f_gnt = 1'b1;
      end
    end
  end

  assign f_gnt_o = f_gnt;
  assign l_gnt_o = l_gnt;

  always_comb begin
    starve_next = '0;
    if (f_req_i && !f_gnt) begin
      if (starve_cnt == LIMIT) starve_next = starve_cnt;
      else                     starve_next = starve_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    mem_csb_o  = 1'b1;
    mem_web_o  = 1'b1;
    mem_addr_o = '0;
    mem_din_o  = '0;
    if (f_gnt) begin
      mem_csb_o  = 1'b0;
      mem_addr_o = f_addr_i[ADDR_W+1:2];
    end else if (l_gnt) begin
      mem_csb_o  = 1'b0;
      mem_web_o  = 1'b0;
      mem_addr_o = l_addr_i[ADDR_W+1:2];
      mem_din_o  = l_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // Responses are gated by reset so a pending read or write done is dropped.
  always_comb begin
    state_next = IDLE;
    f_rvalid_o = 1'b0;
    f_rdata_o  = '0;
    l_done_o   = 1'b0;
    if (f_gnt)      state_next = RD;
    else if (l_gnt) state_next = WR;
    if (!reset_i) begin
      case (state)
        RD: begin
          f_rvalid_o = ~f_flush_i;
          f_rdata_o  = mem_dout_i;
        end
        WR:      l_done_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, then random traffic checked
// against a rule-level reference model with its own copy of memory contents.
module tb_imem_arbiter;
  localparam int ADDR_W = 8;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i = 1'b1;
  logic              f_req_i = 1'b0;
  logic [31:0]       f_addr_i = '0;
  logic              f_flush_i = 1'b0;
  logic              f_gnt_o, f_rvalid_o;
  logic [31:0]       f_rdata_o;
  logic              l_req_i = 1'b0;
  logic [31:0]       l_addr_i = '0;
  logic [31:0]       l_wdata_i = '0;
  logic              l_gnt_o, l_done_o;
  logic              mem_csb_o, mem_web_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_din_o;
  logic [31:0]       mem_dout_i;

  imem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_flush_i(f_flush_i),
    .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o), .f_rdata_o(f_rdata_o),
    .l_req_i(l_req_i), .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
    .l_gnt_o(l_gnt_o), .l_done_o(l_done_o),
    .mem_csb_o(mem_csb_o), .mem_web_o(mem_web_o), .mem_addr_o(mem_addr_o),
    .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // SRAM environment model: one-cycle read latency.
  logic        init_mem = 1'b1;
  logic [31:0] sram [DEPTH];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
    end else if (!mem_csb_o) begin
      if (!mem_web_o) sram[mem_addr_o] <= mem_din_o;
      else            mem_dout_i <= sram[mem_addr_o];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          m_starve = 0;
  bit          m_prev_rd = 0;
  bit          m_prev_wr = 0;
  logic [31:0] m_rdata = '0;

  typedef struct {
    bit          rst, freq, flush, lreq;
    logic [31:0] faddr, laddr, wdata;
    bit          fg, lg, csb, web;
    logic [31:0] addr, din;
    bit          rvalid, done;
    logic [31:0] rdata;
  } vec_t;

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic cycle_check(input string tag, input bit has_vec, input vec_t v);
    bit          e_fg, e_lg;
    logic [31:0] e_addr, e_din, e_rdata;
    @(negedge clk);
    e_fg = 0; e_lg = 0;
    if (!reset_i) begin
      if (f_req_i && l_req_i) begin
        e_fg = (m_starve >= LIMIT);
        e_lg = !e_fg;
      end else begin
        e_fg = f_req_i;
        e_lg = l_req_i;
      end
    end
    e_addr  = e_fg ? 32'(word_of(f_addr_i)) : e_lg ? 32'(word_of(l_addr_i)) : 32'd0;
    e_din   = e_lg ? l_wdata_i : 32'd0;
    e_rdata = (m_prev_rd && !reset_i) ? m_rdata : 32'd0;
    chk({tag, " f_gnt"},  32'(f_gnt_o), 32'(e_fg));
    chk({tag, " l_gnt"},  32'(l_gnt_o), 32'(e_lg));
    chk({tag, " csb"},    32'(mem_csb_o), 32'(!(e_fg || e_lg)));
    chk({tag, " web"},    32'(mem_web_o), 32'(!e_lg));
    chk({tag, " addr"},   32'(mem_addr_o), e_addr);
    chk({tag, " din"},    mem_din_o, e_din);
    chk({tag, " rvalid"}, 32'(f_rvalid_o), 32'(m_prev_rd && !reset_i && !f_flush_i));
    chk({tag, " rdata"},  f_rdata_o, e_rdata);
    chk({tag, " done"},   32'(l_done_o), 32'(m_prev_wr && !reset_i));
    if (has_vec) begin
      chk({tag, " vec f_gnt"},  32'(f_gnt_o), 32'(v.fg));
      chk({tag, " vec l_gnt"},  32'(l_gnt_o), 32'(v.lg));
      chk({tag, " vec csb"},    32'(mem_csb_o), 32'(v.csb));
      chk({tag, " vec web"},    32'(mem_web_o), 32'(v.web));
      chk({tag, " vec addr"},   32'(mem_addr_o), v.addr);
      chk({tag, " vec din"},    mem_din_o, v.din);
      chk({tag, " vec rvalid"}, 32'(f_rvalid_o), 32'(v.rvalid));
      chk({tag, " vec rdata"},  f_rdata_o, v.rdata);
      chk({tag, " vec done"},   32'(l_done_o), 32'(v.done));
    end
    @(posedge clk);
    if (reset_i) begin
      m_starve = 0; m_prev_rd = 0; m_prev_wr = 0;
    end else begin
      m_starve  = (f_req_i && !e_fg) ? ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1) : 0;
      m_prev_rd = e_fg;
      m_prev_wr = e_lg;
      if (e_fg) m_rdata = ref_mem[word_of(f_addr_i)];
      if (e_lg) ref_mem[word_of(l_addr_i)] = l_wdata_i;
    end
    #1;
  endtask

  function automatic vec_t mk(
      input bit rst, input bit freq, input logic [31:0] faddr, input bit flush,
      input bit lreq, input logic [31:0] laddr, input logic [31:0] wdata,
      input bit fg, input bit lg, input bit csb, input bit web,
      input logic [31:0] addr, input logic [31:0] din,
      input bit rvalid, input logic [31:0] rdata, input bit done);
    vec_t v;
    v.rst = rst; v.freq = freq; v.faddr = faddr; v.flush = flush;
    v.lreq = lreq; v.laddr = laddr; v.wdata = wdata;
    v.fg = fg; v.lg = lg; v.csb = csb; v.web = web; v.addr = addr; v.din = din;
    v.rvalid = rvalid; v.rdata = rdata; v.done = done;
    return v;
  endfunction

  vec_t vecs [$];
  vec_t none;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    none = mk(0,0,0,0,0,0,0, 0,0,1,1,0,0, 0,0,0);

    //        rst fq faddr      fl lq laddr      wdata          fg lg csb web addr  din            rv rdata          done
    vecs.push_back(mk(1, 1, 32'h10, 0, 1, 32'h20, 32'h1,        0, 0, 1, 1, 0,    0,             0, 0,             0));
    vecs.push_back(mk(0, 1, 32'h10, 0, 0, 0,      0,            1, 0, 0, 1, 4,    0,             0, 0,             0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0,            0, 0, 1, 1, 0,    0,             1, 32'hA5000004,  0));
    vecs.push_back(mk(0, 0, 0,      0, 1, 32'h20, 32'hDEADBEEF, 0, 1, 0, 0, 8,    32'hDEADBEEF,  0, 0,             0));
    vecs.push_back(mk(0, 1, 32'h20, 0, 0, 0,      0,            1, 0, 0, 1, 8,    0,             0, 0,             1));
    vecs.push_back(mk(0, 1, 32'h13, 0, 0, 0,      0,            1, 0, 0, 1, 4,    0,             1, 32'hDEADBEEF,  0));
    vecs.push_back(mk(0, 1, 32'h0C, 1, 0, 0,      0,            1, 0, 0, 1, 3,    0,             0, 32'hA5000004,  0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0,            0, 0, 1, 1, 0,    0,             1, 32'hA5000003,  0));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk(0, 1, 32'h04, 0, 1, 32'h40, 32'h11110000 + 32'(k),
                        0, 1, 0, 0, 32'h10, 32'h11110000 + 32'(k), 0, 0, k > 1));
    vecs.push_back(mk(0, 1, 32'h04, 0, 1, 32'h40, 32'h11110005, 1, 0, 0, 1, 1,    0,             0, 0,             1));
    vecs.push_back(mk(0, 1, 32'h04, 0, 1, 32'h40, 32'h11110006, 0, 1, 0, 0, 32'h10, 32'h11110006, 1, 32'hA5000001, 0));
    vecs.push_back(mk(1, 1, 32'h04, 0, 1, 32'h40, 32'h11110007, 0, 0, 1, 1, 0,    0,             0, 0,             0));
    vecs.push_back(mk(0, 1, 32'h04, 0, 1, 32'h44, 32'h22220000, 0, 1, 0, 0, 32'h11, 32'h22220000, 0, 0,            0));
    vecs.push_back(mk(0, 0, 0,      0, 0, 0,      0,            0, 0, 1, 1, 0,    0,             0, 0,             1));

    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;

    foreach (vecs[i]) begin
      reset_i = vecs[i].rst; f_req_i = vecs[i].freq; f_addr_i = vecs[i].faddr;
      f_flush_i = vecs[i].flush; l_req_i = vecs[i].lreq; l_addr_i = vecs[i].laddr;
      l_wdata_i = vecs[i].wdata;
      cycle_check($sformatf("vec%0d", i), 1'b1, vecs[i]);
    end

    // Reset while a read is pending drops the response; nothing follows release.
    reset_i = 0; f_req_i = 1; f_addr_i = 32'h08; l_req_i = 0; f_flush_i = 0;
    cycle_check("rdrst grant", 1'b0, none);
    reset_i = 1; f_req_i = 0;
    cycle_check("rdrst in_reset", 1'b0, none);
    reset_i = 0;
    cycle_check("rdrst release", 1'b0, none);
    chk("rdrst no pulse", 32'(f_rvalid_o), 32'd0);

    // Continuous contention: four loader grants, then one fetch, repeating.
    begin
      int fcount = 0;
      f_req_i = 1; l_req_i = 1; f_addr_i = 32'h30; l_addr_i = 32'h50;
      for (int c = 0; c < 15; c++) begin
        l_wdata_i = 32'hC0DE0000 + 32'(c);
        #3;
        if (c % 5 == 4) begin
          chk($sformatf("starve fetch c%0d", c), 32'(f_gnt_o), 32'd1);
          fcount++;
        end else begin
          chk($sformatf("starve loader c%0d", c), 32'(l_gnt_o), 32'd1);
        end
        cycle_check($sformatf("starve c%0d", c), 1'b0, none);
      end
      chk("starve fetch count", 32'(fcount), 32'd3);
    end

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      reset_i   = ($urandom_range(0, 39) == 0);
      f_req_i   = ($urandom_range(0, 9) < 7);
      l_req_i   = ($urandom_range(0, 9) < 6);
      f_flush_i = ($urandom_range(0, 3) == 0);
      f_addr_i  = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 15)) << 2;
      l_addr_i  = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 15)) << 2;
      l_wdata_i = $urandom();
      cycle_check($sformatf("rand%0d", c), 1'b0, none);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, giving the SRAM word-address width.
REQ-002 The module SHALL have parameter STARVE_LIMIT, default 4, giving the maximum consecutive fetch denials before fetch is forced a grant.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port: clk_i  in  1  clock; all state updates on rising edge.
REQ-005 Port: reset_i  in  1  synchronous active-high reset.
REQ-006 Port: f_req_i  in  1  fetch read request.
REQ-007 Port: f_addr_i  in  32  fetch byte address.
REQ-008 Port: f_flush_i  in  1  discard any read response due this cycle.
REQ-009 Port: f_gnt_o  out  1  fetch request accepted this cycle (combinational).
REQ-010 Port: f_rvalid_o  out  1  fetch read data valid.
REQ-011 Port: f_rdata_o  out  32  fetch read data.
REQ-012 Port: l_req_i  in  1  loader write request.
REQ-013 Port: l_addr_i  in  32  loader byte address.
REQ-014 Port: l_wdata_i  in  32  loader write data.
REQ-015 Port: l_gnt_o  out  1  loader request accepted this cycle (combinational).
REQ-016 Port: l_done_o  out  1  one-cycle pulse; write completed.
REQ-017 Port: mem_csb_o  out  1  SRAM chip select, active-low.
REQ-018 Port: mem_web_o  out  1  SRAM write enable, active-low.
REQ-019 Port: mem_addr_o  out  ADDR_W  SRAM word address.
REQ-020 Port: mem_din_o  out  32  SRAM write data.
REQ-021 Port: mem_dout_i  in  32  SRAM read data; valid one cycle after a read select.

Function
REQ-022 Arbitration: at most one of f_gnt_o and l_gnt_o SHALL be high per cycle.
REQ-023 Priority: loader wins when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-024 starve_cnt: +1 on cycles with f_req_i high and f_gnt_o low; cleared on f_gnt_o or f_req_i low; saturates at STARVE_LIMIT.
REQ-025 Sole requester: that requester SHALL be granted the same cycle.
REQ-026 Memory drive on grant: mem_csb_o=0; mem_addr_o = granted addr[ADDR_W+1:2]; addr[1:0] ignored.
REQ-027 Memory drive on fetch grant: mem_web_o=1.
REQ-028 Memory drive on loader grant: mem_web_o=0; mem_din_o = l_wdata_i.
REQ-029 No grant: mem_csb_o=1, mem_web_o=1, mem_addr_o and mem_din_o zero.
REQ-030 FSM states, registered: IDLE (no grant last cycle), RD (fetch grant last cycle), WR (loader grant last cycle); next state set solely by this cycle's grant.
REQ-031 In RD: f_rvalid_o = ~f_flush_i, f_rdata_o = mem_dout_i; all other states f_rvalid_o=0, f_rdata_o=0.
REQ-032 In WR: l_done_o=1; else 0.
REQ-033 Latency: read grant in cycle N gives f_rvalid_o in N+1; back-to-back grants give one response per cycle.
REQ-034 Flush: f_flush_i affects only the response due this cycle, not arbitration or a grant in the same cycle.
REQ-035 Loader write to an address followed next cycle by a fetch read of it SHALL return the new data.

Reset
REQ-036 Reset SHALL set state=IDLE and starve_cnt=0.
REQ-037 During reset, f_gnt_o, l_gnt_o, f_rvalid_o, l_done_o SHALL be 0, f_rdata_o=0, mem_csb_o=1, mem_web_o=1.
REQ-038 Reset asserted while in RD or WR SHALL drop the pending response/done; no pulse appears after reset release.

Verification
REQ-039 Fetch only: f_req_i=1, f_addr_i=0x10 -> f_gnt_o=1, mem_addr_o=4, mem_web_o=1; next cycle f_rvalid_o=1, f_rdata_o=mem word 4.
REQ-040 Write then read: loader writes 0xDEADBEEF @0x20; next cycle fetch reads 0x20 -> l_done_o pulse, then f_rdata_o=0xDEADBEEF.
REQ-041 Starvation: both requesting continuously, STARVE_LIMIT=4 -> 4 loader grants, 1 fetch grant, repeating.
REQ-042 Flush: fetch grant cycle N, f_flush_i=1 in N+1 -> f_rvalid_o=0 in N+1; a new grant in N+1 still responds in N+2.
REQ-043 Reset mid-operation: loader grant cycle N, reset_i=1 in N+1 -> l_done_o=0 in N+1 and after; starve_cnt=0.
REQ-044 Misaligned address: f_addr_i=0x13 -> mem_addr_o=4.
